firebird7_in_gate1_tessent_scanmux_secure_nway: RTL and testbench

FIREBIRD7_IN_GATE1_TESSENT_SCANMUX_SECURE_NWAY -- requirements
Module: firebird7_in_gate1_tessent_scanmux_secure_nway

---
 rtl/firebird7_in_gate1_tessent_scanmux_secure_nway_if.sv | 30 +++
 rtl/firebird7_in_gate1_tessent_scanmux_secure_nway.sv | 82 ++++++++
 tb/tb_firebird7_in_gate1_tessent_scanmux_secure_nway.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/firebird7_in_gate1_tessent_scanmux_secure_nway_if.sv
// Port bundle for the secure N-way IJTAG scan mux.
// The TAP-side controller or bench drives the master side. The mux block is the slave side.
interface firebird7_in_gate1_tessent_scanmux_secure_nway_if #(
    parameter int N_IN = 4
);
    logic            ijtag_sel;
    logic            ijtag_ce;
    logic            ijtag_se;
    logic            ijtag_ue;
    logic            ijtag_si;
    logic            ijtag_so;
    logic [N_IN-1:0] mux_in;
    logic            mux_out;
    logic            enable_in;
    logic [N_IN-1:0] enable_out;
    logic            secure_unlock;
    logic            sel_violation;

    modport master (
        output ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si,
        output mux_in, enable_in, secure_unlock,
        input  ijtag_so, mux_out, enable_out, sel_violation
    );

    modport slave (
        input  ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si,
        input  mux_in, enable_in, secure_unlock,
        output ijtag_so, mux_out, enable_out, sel_violation
    );
endinterface

// File: rtl/firebird7_in_gate1_tessent_scanmux_secure_nway.sv
// Secure N-way IJTAG scan mux. A scan-programmed select register drives a shadowed branch select.
// The shadow is forced back to branch 0 whenever the security controller withholds unlock.
module firebird7_in_gate1_tessent_scanmux_secure_nway #(
    parameter int N_IN      = 4,
    parameter int RESET_SEL = 0
) (
    input logic ijtag_tck,
    input logic ijtag_reset,
    firebird7_in_gate1_tessent_scanmux_secure_nway_if.slave bus
);
    localparam int SEL_W = (N_IN > 2) ? $clog2(N_IN) : 1;
    localparam int SR_W  = SEL_W + 1;

    logic [SR_W-1:0]  sr_q, sr_d;
    logic [SEL_W-1:0] shd_q, shd_d;
    logic             vio_q, vio_d;

    logic [SEL_W-1:0] upd_v;
    logic             upd_w;
    logic             v_in_range;
    logic [N_IN-1:0]  enable_d;

    always_comb begin
        sr_d       = sr_q;
        shd_d      = shd_q;
        vio_d      = vio_q;
        upd_v      = sr_q[SEL_W-1:0];
        upd_w      = sr_q[SR_W-1];
        v_in_range = (int'(upd_v) < N_IN);

        if (bus.ijtag_sel) begin
            if (bus.ijtag_ce) begin
                sr_d = {vio_q, shd_q};
            end else if (bus.ijtag_se) begin
                sr_d = {bus.ijtag_si, sr_q[SR_W-1:1]};
            end

            // Update always decodes the pre-edge register contents, even when a capture or shift happens on the same edge.
            if (bus.ijtag_ue) begin
                if (!v_in_range) begin
                    vio_d = 1'b1;
                end else if (bus.secure_unlock || (upd_v == '0)) begin
                    shd_d = upd_v;
                    if (bus.secure_unlock && upd_w) begin
                        vio_d = 1'b0;
                    end
                end else begin
                    vio_d = 1'b1;
                end
            end
        end

        // The lock wins over everything, including a deselected segment.
        if (!bus.secure_unlock && (shd_q != '0)) begin
            shd_d = '0;
        end
    end

    always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
        if (!ijtag_reset) begin
            sr_q  <= '0;
            shd_q <= SEL_W'(RESET_SEL);
            vio_q <= 1'b0;
        end else begin
            sr_q  <= sr_d;
            shd_q <= shd_d;
            vio_q <= vio_d;
        end
    end

    always_comb begin
        enable_d = '0;
        for (int i = 0; i < N_IN; i++) begin
            enable_d[i] = bus.enable_in && (int'(shd_q) == i);
        end
    end

    assign bus.ijtag_so      = sr_q[0];
    assign bus.sel_violation = vio_q;
    assign bus.mux_out       = bus.mux_in[shd_q];
    assign bus.enable_out    = enable_d;
endmodule

// File: tb/tb_firebird7_in_gate1_tessent_scanmux_secure_nway.sv
// Directed scoreboard bench driving a 4-way and a 3-way instance with identical stimulus.
// Each step queues its expected values, and the queue is drained against both DUTs.
module tb_firebird7_in_gate1_tessent_scanmux_secure_nway;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       sel, ce, se, ue, si, unlock, en_in;
    logic [3:0] mux_v;

    always #5 clk = ~clk;

    firebird7_in_gate1_tessent_scanmux_secure_nway_if #(.N_IN(4)) b4 ();
    firebird7_in_gate1_tessent_scanmux_secure_nway_if #(.N_IN(3)) b3 ();

    assign b4.ijtag_sel = sel;       assign b3.ijtag_sel = sel;
    assign b4.ijtag_ce = ce;         assign b3.ijtag_ce = ce;
    assign b4.ijtag_se = se;         assign b3.ijtag_se = se;
    assign b4.ijtag_ue = ue;         assign b3.ijtag_ue = ue;
    assign b4.ijtag_si = si;         assign b3.ijtag_si = si;
    assign b4.secure_unlock = unlock; assign b3.secure_unlock = unlock;
    assign b4.enable_in = en_in;     assign b3.enable_in = en_in;
    assign b4.mux_in = mux_v;        assign b3.mux_in = mux_v[2:0];

    firebird7_in_gate1_tessent_scanmux_secure_nway #(.N_IN(4), .RESET_SEL(0)) u_dut4 (
        .ijtag_tck(clk), .ijtag_reset(rst_n), .bus(b4.slave)
    );
    firebird7_in_gate1_tessent_scanmux_secure_nway #(.N_IN(3), .RESET_SEL(0)) u_dut3 (
        .ijtag_tck(clk), .ijtag_reset(rst_n), .bus(b3.slave)
    );

    typedef struct {
        string       tag;
        int          kind;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic logic [31:0] obs(int kind);
        case (kind)
            0:       return 32'(b4.ijtag_so);
            1:       return 32'(b4.sel_violation);
            2:       return 32'(b4.mux_out);
            3:       return 32'(b4.enable_out);
            4:       return 32'(b3.ijtag_so);
            5:       return 32'(b3.sel_violation);
            6:       return 32'(b3.mux_out);
            default: return 32'(b3.enable_out);
        endcase
    endfunction

    task automatic push(input string tag, input int kind, input logic [31:0] exp);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    task automatic push_state(input string tag, input int shd4, input logic vio4,
                              input int shd3, input logic vio3);
        logic [3:0] m;
        logic [3:0] one4;
        logic [2:0] one3;
        m    = mux_v;
        one4 = 4'(1 << shd4);
        one3 = 3'(1 << shd3);
        push({tag, "_vio4"}, 1, 32'(vio4));
        push({tag, "_mux4"}, 2, 32'(m[shd4]));
        push({tag, "_en4"},  3, 32'(one4));
        push({tag, "_vio3"}, 5, 32'(vio3));
        push({tag, "_mux3"}, 6, 32'(m[shd3]));
        push({tag, "_en3"},  7, 32'(one3));
    endtask

    task automatic push_so(input string tag, input logic so4, input logic so3);
        push({tag, "_so4"}, 0, 32'(so4));
        push({tag, "_so3"}, 4, 32'(so3));
    endtask

    task automatic check_all();
        exp_t        e;
        logic [31:0] o;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = obs(e.kind);
            n_cmp++;
            assert (o === e.exp) else begin
                n_err++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, o, e.exp);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic shift3(input logic [2:0] b);
        sel = 1'b1;
        se  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            si = b[i];
            step();
        end
        se = 1'b0;
        si = 1'b0;
    endtask

    task automatic update();
        ue = 1'b1;
        step();
        ue = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; sel = 1'b0; ce = 1'b0; se = 1'b0; ue = 1'b0; si = 1'b0;
        unlock = 1'b0; en_in = 1'b1; mux_v = 4'b0110;
        #2;
        push_state("reset", 0, 1'b0, 0, 1'b0);
        push_so("reset", 1'b0, 1'b0);
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Unlocked select of branch 2.
        unlock = 1'b1;
        shift3(3'b010);
        update();
        push_state("sel2", 2, 1'b0, 2, 1'b0);
        push_so("sel2", 1'b0, 1'b0);
        check_all();
        en_in = 1'b0;
        #1;
        push("en_off4", 3, 32'h0);
        push("en_off3", 7, 32'h0);
        check_all();
        en_in = 1'b1;

        // Dropping unlock pulls the shadow back to 0 without a violation.
        unlock = 1'b0;
        sel    = 1'b1;
        step();
        push_state("lock_force", 0, 1'b0, 0, 1'b0);
        check_all();

        // A locked update of 3 is rejected, and the violation reads back through capture.
        shift3(3'b011);
        update();
        push_state("locked_upd", 0, 1'b1, 0, 1'b1);
        check_all();
        ce = 1'b1;
        step();
        ce = 1'b0;
        push_so("cap_so0", 1'b0, 1'b0);
        check_all();
        se = 1'b1;
        si = 1'b0;
        step();
        push_so("cap_so1", 1'b0, 1'b0);
        check_all();
        step();
        se = 1'b0;
        push_so("cap_so2", 1'b1, 1'b1);
        check_all();

        // Clearing with w=1 and v=0 while unlocked.
        unlock = 1'b1;
        shift3(3'b100);
        update();
        push_state("clear", 0, 1'b0, 0, 1'b0);
        check_all();

        // v=3 is the top legal branch on the 4-way instance and out of range on the 3-way instance.
        shift3(3'b011);
        update();
        push_state("v3", 3, 1'b0, 0, 1'b1);
        check_all();

        // Unlock drops on the same edge as an update of v=1.
        shift3(3'b001);
        unlock = 1'b0;
        update();
        push_state("lock_vs_upd", 0, 1'b1, 0, 1'b1);
        check_all();

        unlock = 1'b1;
        shift3(3'b100);
        update();
        push_state("clear2", 0, 1'b0, 0, 1'b0);
        check_all();

        // For w=1 with v=3, the out-of-range set beats the clear on the 3-way instance.
        shift3(3'b111);
        update();
        push_state("set_wins", 3, 1'b0, 0, 1'b1);
        check_all();

        // With ce and se both high, capture wins.
        sel = 1'b1; ce = 1'b1; se = 1'b1; si = 1'b0;
        step();
        ce = 1'b0; se = 1'b0;
        push_so("ce_over_se", 1'b1, 1'b0);
        check_all();

        // A deselected segment ignores shift and update.
        sel = 1'b0; se = 1'b1; si = 1'b1; ue = 1'b1;
        step();
        step();
        se = 1'b0; ue = 1'b0; si = 1'b0;
        push_so("sel0_hold", 1'b1, 1'b0);
        push_state("sel0_hold", 3, 1'b0, 0, 1'b1);
        check_all();

        sel = 1'b1;
        shift3(3'b100);
        update();
        push_state("clear3", 0, 1'b0, 0, 1'b0);
        check_all();

        // Reset lands in the middle of a shift.
        shift3(3'b111);
        update();
        push_state("pre_rst", 3, 1'b0, 0, 1'b1);
        check_all();
        se = 1'b1;
        si = 1'b1;
        step();
        step();
        push_so("mid_shift", 1'b1, 1'b1);
        check_all();
        #1;
        rst_n = 1'b0;
        #1;
        push_state("async_rst", 0, 1'b0, 0, 1'b0);
        push_so("async_rst", 1'b0, 1'b0);
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        se = 1'b0;
        push_so("post_rst_shift", 1'b0, 1'b0);
        push_state("post_rst_shift", 0, 1'b0, 0, 1'b0);
        check_all();
        step();
        push_so("post_rst_shift2", 1'b0, 1'b0);
        check_all();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
